// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the WB stage has priority, MDU results wait in a
// small FIFO and drain into writeback bubbles, and a busy scoreboard feeds the hazard unit.
module rf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wr_en,
  input  logic [4:0]  pipe_wr_addr,
  input  logic [31:0] pipe_wr_data,
  input  logic        mdu_wr_valid,
  input  logic [4:0]  mdu_wr_addr,
  input  logic [31:0] mdu_wr_data,
  output logic        mdu_wr_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  query_rs,
  input  logic [4:0]  query_rt,
  input  logic [4:0]  query_rd,
  output logic        hazard,
  output logic [31:0] busy,
  output logic        stall_req,
  output logic        rf_reg_write,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [3:0]  LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [4:0]  fifo_addr [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic        empty, full, empty_next;
  logic        store, pipe_grant, pop;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic [31:0] busy_next;
  logic [3:0]  age, age_next;
  logic        stall_next;

  // Extra pointer MSB tells full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign mdu_wr_ready = !full && !rst;
  assign store        = mdu_wr_valid && mdu_wr_ready && (mdu_wr_addr != 5'd0);

  assign pipe_grant = pipe_wr_en && (pipe_wr_addr != 5'd0);
  assign pop        = !pipe_grant && !empty;

  assign head_addr = fifo_addr[rd_ptr[AW-1:0]];
  assign head_data = fifo_data[rd_ptr[AW-1:0]];

  assign wr_ptr_next = store ? wr_ptr + PTR_ONE : wr_ptr;
  assign rd_ptr_next = pop   ? rd_ptr + PTR_ONE : rd_ptr;
  assign empty_next  = (wr_ptr_next == rd_ptr_next);

  assign hazard = ((query_rs != 5'd0) && busy[query_rs]) ||
                  ((query_rt != 5'd0) && busy[query_rt]) ||
                  ((query_rd != 5'd0) && busy[query_rd]);

  always_comb begin
    // NOTE: every variable gets a default first so always_comb never infers a latch.
    busy_next = busy;
    if (pop) busy_next[head_addr] = 1'b0;
    // Set after clear so a same-cycle issue to the popped register keeps it busy.
    if (issue_valid && (issue_addr != 5'd0)) busy_next[issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    age_next = age;
    if (pop || empty)        age_next = 4'd0;
    else if (age != 4'hF)    age_next = age + 4'd1;
    stall_next = (age_next >= LIMIT) && !empty_next;
  end

  // NOTE: payload storage has no reset; validity comes entirely from the pointers,
  // so a reset that empties the pointers makes the stale contents unreachable.
  always_ff @(posedge clk) begin
    if (store) begin
      fifo_addr[wr_ptr[AW-1:0]] <= mdu_wr_addr;
      fifo_data[wr_ptr[AW-1:0]] <= mdu_wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      busy      <= '0;
      age       <= 4'd0;
      stall_req <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      busy      <= busy_next;
      age       <= age_next;
      stall_req <= stall_next;
    end
  end

  // Address and data hold their last values when there is no grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_reg_write  <= 1'b0;
      rf_write_reg  <= 5'd0;
      rf_write_data <= 32'd0;
    end else begin
      rf_reg_write <= pipe_grant || pop;
      if (pipe_grant) begin
        rf_write_reg  <= pipe_wr_addr;
        rf_write_data <= pipe_wr_data;
      end else if (pop) begin
        rf_write_reg  <= head_addr;
        rf_write_data <= head_data;
      end
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Arbitrates the register file's single write port between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). It buffers MDU results in a small FIFO and drains them into pipeline writeback bubbles. It also keeps a per-register busy scoreboard so the hazard unit can stall issue of any instruction touching a register with an MDU write still in flight. The block sits between the WB stage/MDU and the register file write inputs (`reg_write`, `write_reg`, `write_data`).

## Interface
- `DEPTH`, 2: MDU result FIFO entries (power of two, 2..8).
- `STARVE_LIMIT`, 4: cycles the FIFO head may wait before `stall_req` asserts (1..15).

- `clk` in 1: the single clock; all state is updated on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pipe_wr_en` in 1: WB stage write request; always accepted.
- `pipe_wr_addr` in 5: WB destination register.
- `pipe_wr_data` in 32: WB data.
- `mdu_wr_valid` in 1: MDU result valid.
- `mdu_wr_addr` in 5: MDU destination register.
- `mdu_wr_data` in 32: MDU result.
- `mdu_wr_ready` out 1: FIFO can accept a result.
- `issue_valid` in 1: an MDU op issued this cycle; marks its destination busy.
- `issue_addr` in 5: destination of the issued MDU op.
- `query_rs`, `query_rt`, `query_rd` in 5 each: registers used by the instruction in decode.
- `hazard` out 1: combinational; set if any nonzero query register is busy.
- `busy` out 32: scoreboard bit vector.
- `stall_req` out 1: registered; requests that upstream insert a writeback bubble.
- `rf_reg_write` out 1: registered write enable to the register file.
- `rf_write_reg` out 5: registered write address to the register file.
- `rf_write_data` out 32: registered write data to the register file.

## Operation
- FIFO push happens on `mdu_wr_valid && mdu_wr_ready`.
- `mdu_wr_ready = !full && !rst`.
- A pushed entry whose address is 0 is discarded (not stored).
- Each cycle exactly one source is granted, evaluated in this order:
  1. `pipe_wr_en && pipe_wr_addr != 0`: grant the pipeline.
  2. Otherwise, if the FIFO is non-empty: grant and pop the FIFO head.
  3. Otherwise: no write.
- The pipeline always has priority.
- `pipe_wr_en` with address 0 counts as a bubble, so the FIFO may drain that cycle.
- The granted write is registered into `rf_*` for the next cycle.
- `rf_reg_write=0` when there is no grant; `rf_write_reg` and `rf_write_data` hold their last values.
- Scoreboard:
  - `issue_valid` with `issue_addr != 0` sets `busy[issue_addr]`.
  - A FIFO pop clears `busy[head_addr]`.
  - If set and clear hit the same address in the same cycle, set wins.
  - `busy[0]` is always 0.
- `hazard = (busy[query_rs] | busy[query_rt] | busy[query_rd])`, with any term for a zero address forced to 0.
- Starvation counter `age` (4 bits):
  - Resets to 0 on reset, on a pop, and whenever the FIFO is empty.
  - Otherwise increments when the head is not granted, saturating at 15.
  - `stall_req` is registered and equals `(age >= STARVE_LIMIT) && !empty` after the edge.
- Upstream contract: when `stall_req` is seen, upstream drives `pipe_wr_en=0` the next cycle. The head then pops and `stall_req` drops.
- Simultaneous push and pop on a full FIFO:
  - `mdu_wr_ready` is 0 when full, so no push is accepted that cycle.
  - A push while not full, concurrent with a pop, is legal and leaves the count unchanged.
- The FIFO uses read/write pointers of width log2(DEPTH)+1; wrap-around is via the MSB compare.

## Timing
- Reset (asynchronous, immediate):
  - `rf_reg_write=0`, `rf_write_reg=0`, `rf_write_data=0`.
  - `busy=0`, `stall_req=0`, FIFO empty, `age=0`.
  - `mdu_wr_ready=0`, `hazard=0`.
- Reset mid-operation drops all buffered MDU results and busy bits. The MDU is reset by the same `rst`.
- Pipeline write latency: 1 cycle (inputs at edge N, `rf_reg_write` high after edge N).
- MDU write, best case: accepted at edge N, popped at edge N+1, `rf_reg_write` high after edge N+1.
- Busy bit timing:
  - Set visible after the issue edge.
  - Cleared after the pop edge, in the same cycle `rf_*` carries the write.
  - The register file therefore holds the value one edge after `hazard` drops. The decode read path must bypass, or the hazard unit stalls one extra cycle; this is the WB-forward path already in the pipeline.

## Test plan
- **Reset:** assert `rst` mid-cycle with FIFO holding 2 entries and `busy[5]=1`.
  - Outputs go to zero immediately.
  - After release, `mdu_wr_ready=1` and `busy=0`.
- **Pipeline only:** `pipe_wr_en=1`, addr 3, data 0xDEADBEEF.
  - Next cycle: `rf_reg_write=1`, `rf_write_reg=3`, `rf_write_data=0xDEADBEEF`.
  - Address 0 with data 0x1: `rf_reg_write=0`.
- **Bubble drain:** issue to addr 8, then MDU result 0x12345678 to addr 8 with the pipeline idle.
  - `hazard=1` for `query_rs=8` until the pop.
  - `rf` write to 8 with 0x12345678 two edges after the push.
  - `busy[8]` clears.
- **Full FIFO:** push 2 results while `pipe_wr_en=1` (addr 1) continuously.
  - `mdu_wr_ready=0`.
  - Third `mdu_wr_valid` is held off.
  - FIFO order is preserved when draining.
- **Starvation:** FIFO non-empty, `pipe_wr_en=1` every cycle.
  - `stall_req=1` after 4 ungranted cycles.
  - Bench drops `pipe_wr_en` for one cycle: head pops, `stall_req=0`, age resets.
- **Same-cycle set/clear:** pop of addr 9 coincides with `issue_valid` addr 9.
  - `busy[9]` stays 1.
